// File: rtl/reg_scoreboard.sv
// reg_scoreboard: GPR write-pending scoreboard for a pipelined core.
// Each register 1..31 has a 2-bit count of in-flight writers and the
// remaining Tnew of the newest writer. Decode queries two sources and gets
// busy/tnew back, plus a stall decision against the sources' Tuse.
// Optional build macro: REG_SCOREBOARD_TRACE_EN prints one line per
// accepted issue and per commit to a nonzero register.
module reg_scoreboard (
  input  logic       clk,
  input  logic       reset,
  input  logic       issue_valid,
  input  logic [4:0] issue_rd,
  input  logic [2:0] issue_lat,
  output logic       issue_ready,
  input  logic       commit_valid,
  input  logic [4:0] commit_rd,
  input  logic [4:0] query_rs,
  input  logic [4:0] query_rt,
  input  logic       use_rs,
  input  logic       use_rt,
  input  logic [1:0] rs_tuse,
  input  logic [1:0] rt_tuse,
  output logic       rs_busy,
  output logic       rt_busy,
  output logic [2:0] rs_tnew,
  output logic [2:0] rt_tnew,
  output logic       stall,
  output logic       err_underflow
);

  logic [1:0] cnt      [32];
  logic [2:0] tnew     [32];
  logic [1:0] cnt_nxt  [32];
  logic [2:0] tnew_nxt [32];
  logic       err_nxt;
  logic       iss_acc;
  logic       cmt_act;
  logic       same_reg;

  // A full counter on the destination back-pressures the issue.
  assign issue_ready = !((issue_rd != 5'd0) && (cnt[issue_rd] == 2'd3));
  assign iss_acc     = issue_valid && issue_ready && (issue_rd != 5'd0);
  assign cmt_act     = commit_valid && (commit_rd != 5'd0);
  assign same_reg    = iss_acc && cmt_act && (issue_rd == commit_rd);

  // Next-state for every register: age tnew, then apply issue/commit.
  always_comb begin
    err_nxt = err_underflow;
    for (int r = 0; r < 32; r++) begin
      cnt_nxt[r]  = cnt[r];
      tnew_nxt[r] = (tnew[r] != 3'd0) ? tnew[r] - 3'd1 : 3'd0;
    end
    for (int r = 1; r < 32; r++) begin
      if (same_reg && (issue_rd == 5'(r))) begin
        // One writer retires while another enters: count is unchanged.
        tnew_nxt[r] = issue_lat;
      end else if (iss_acc && (issue_rd == 5'(r))) begin
        cnt_nxt[r]  = cnt[r] + 2'd1;
        tnew_nxt[r] = issue_lat;
      end else if (cmt_act && (commit_rd == 5'(r))) begin
        if (cnt[r] != 2'd0) begin
          cnt_nxt[r] = cnt[r] - 2'd1;
          if (cnt[r] == 2'd1) tnew_nxt[r] = 3'd0;
        end
      end
    end
    if (cmt_act && !same_reg && (cnt[commit_rd] == 2'd0)) err_nxt = 1'b1;
    cnt_nxt[0]  = 2'd0;
    tnew_nxt[0] = 3'd0;
  end

  // Register state; synchronous reset discards same-cycle issue/commit.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < 32; r++) begin
        cnt[r]  <= 2'd0;
        tnew[r] <= 3'd0;
      end
      err_underflow <= 1'b0;
    end else begin
      for (int r = 0; r < 32; r++) begin
        cnt[r]  <= cnt_nxt[r];
        tnew[r] <= tnew_nxt[r];
      end
      err_underflow <= err_nxt;
    end
  end

  assign rs_busy = (query_rs != 5'd0) && (cnt[query_rs] != 2'd0);
  assign rt_busy = (query_rt != 5'd0) && (cnt[query_rt] != 2'd0);
  assign rs_tnew = (query_rs != 5'd0) ? tnew[query_rs] : 3'd0;
  assign rt_tnew = (query_rt != 5'd0) ? tnew[query_rt] : 3'd0;
  assign stall   = (use_rs && rs_busy && (rs_tnew > {1'b0, rs_tuse})) ||
                   (use_rt && rt_busy && (rt_tnew > {1'b0, rt_tuse}));

`ifdef REG_SCOREBOARD_TRACE_EN
  // Event trace showing the post-update count.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (iss_acc)
        $display("%0t ISS r%0d cnt=%0d", $time, issue_rd, cnt_nxt[issue_rd]);
      if (cmt_act)
        $display("%0t CMT r%0d cnt=%0d", $time, commit_rd, cnt_nxt[commit_rd]);
    end
  end
`endif

endmodule

// File: tb/tb_reg_scoreboard.sv
// tb_reg_scoreboard: directed and random stimulus for reg_scoreboard with a
// queue-based scoreboard; a monitor checks outputs on the falling edge.
module tb_reg_scoreboard;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       issue_valid = 1'b0;
  logic [4:0] issue_rd = '0;
  logic [2:0] issue_lat = '0;
  logic       issue_ready;
  logic       commit_valid = 1'b0;
  logic [4:0] commit_rd = '0;
  logic [4:0] query_rs = '0;
  logic [4:0] query_rt = '0;
  logic       use_rs = 1'b0;
  logic       use_rt = 1'b0;
  logic [1:0] rs_tuse = '0;
  logic [1:0] rt_tuse = '0;
  logic       rs_busy, rt_busy, stall, err_underflow;
  logic [2:0] rs_tnew, rt_tnew;

  reg_scoreboard dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_lat(issue_lat),
    .issue_ready(issue_ready),
    .commit_valid(commit_valid), .commit_rd(commit_rd),
    .query_rs(query_rs), .query_rt(query_rt),
    .use_rs(use_rs), .use_rt(use_rt),
    .rs_tuse(rs_tuse), .rt_tuse(rt_tuse),
    .rs_busy(rs_busy), .rt_busy(rt_busy),
    .rs_tnew(rs_tnew), .rt_tnew(rt_tnew),
    .stall(stall), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    bit         chk;
    logic [10:0] exp;
  } item_t;

  item_t q[$];
  int    n_vec  = 0;
  int    n_fail = 0;

  // Reference model: pending writers per register and newest writer's Tnew.
  int m_cnt  [32];
  int m_tnew [32];
  bit m_err;

  // Packing: {ready, rs_busy, rt_busy, rs_tnew, rt_tnew, stall, err}
  function automatic logic [10:0] expect_now();
    int  bs, bt, ts, tt;
    bit  rdy, stl;
    bs  = (query_rs != 0 && m_cnt[query_rs] > 0) ? 1 : 0;
    bt  = (query_rt != 0 && m_cnt[query_rt] > 0) ? 1 : 0;
    ts  = (query_rs != 0) ? m_tnew[query_rs] : 0;
    tt  = (query_rt != 0) ? m_tnew[query_rt] : 0;
    rdy = !(issue_rd != 0 && m_cnt[issue_rd] == 3);
    stl = (use_rs && bs == 1 && ts > int'(rs_tuse)) ||
          (use_rt && bt == 1 && tt > int'(rt_tuse));
    return {rdy, bs[0], bt[0], ts[2:0], tt[2:0], stl, m_err};
  endfunction

  function automatic void model_step();
    bit acc, cm;
    if (reset) begin
      for (int r = 0; r < 32; r++) begin m_cnt[r] = 0; m_tnew[r] = 0; end
      m_err = 0;
      return;
    end
    acc = issue_valid && issue_rd != 0 && m_cnt[issue_rd] < 3;
    cm  = commit_valid && commit_rd != 0;
    for (int r = 1; r < 32; r++) if (m_tnew[r] > 0) m_tnew[r]--;
    if (acc && cm && issue_rd == commit_rd) begin
      m_tnew[issue_rd] = int'(issue_lat);
    end else begin
      if (acc) begin
        m_cnt[issue_rd]++;
        m_tnew[issue_rd] = int'(issue_lat);
      end
      if (cm) begin
        if (m_cnt[commit_rd] > 0) begin
          m_cnt[commit_rd]--;
          if (m_cnt[commit_rd] == 0) m_tnew[commit_rd] = 0;
        end else m_err = 1;
      end
    end
  endfunction

  // Queue the expected response for the current inputs, then advance a cycle.
  task automatic apply(input string name, input bit chk);
    item_t it;
    it.name = name;
    it.chk  = chk;
    it.exp  = expect_now();
    q.push_back(it);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    reset = 0; issue_valid = 0; issue_rd = 0; issue_lat = 0;
    commit_valid = 0; commit_rd = 0; query_rs = 0; query_rt = 0;
    use_rs = 0; use_rt = 0; rs_tuse = 0; rt_tuse = 0;
  endtask

  task automatic iss(input int rd, input int lat);
    issue_valid = 1; issue_rd = 5'(rd); issue_lat = 3'(lat);
  endtask

  task automatic cmt(input int rd);
    commit_valid = 1; commit_rd = 5'(rd);
  endtask

  // Monitor: compare each queued expectation against the DUT.
  initial begin
    item_t it;
    logic [10:0] act;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        it  = q.pop_front();
        act = {issue_ready, rs_busy, rt_busy, rs_tnew, rt_tnew, stall, err_underflow};
        if (it.chk) begin
          n_vec++;
          if (act !== it.exp) begin
            n_fail++;
            $display("FAIL %s: got rdy/bs/bt/ts/tt/stl/err=%b_%b_%b_%0d_%0d_%b_%b want %b_%b_%b_%0d_%0d_%b_%b",
                     it.name, act[10], act[9], act[8], act[7:5], act[4:2], act[1], act[0],
                     it.exp[10], it.exp[9], it.exp[8], it.exp[7:5], it.exp[4:2], it.exp[1], it.exp[0]);
          end
        end
      end
    end
  end

  initial begin
    int budget;
    @(posedge clk); #1;
    clr(); reset = 1; apply("init_reset", 0);

    // Reset state with a query on an idle register.
    clr(); query_rs = 5; use_rs = 1; apply("reset_state", 1);

    // Issue r8 lat 3, then watch Tnew count down against tuse 1.
    clr(); iss(8, 3); apply("iss_r8", 1);
    clr(); query_rs = 8; use_rs = 1; rs_tuse = 1; apply("r8_tnew3", 1);
    clr(); query_rs = 8; use_rs = 1; rs_tuse = 1; apply("r8_tnew2", 1);
    clr(); query_rs = 8; use_rs = 1; rs_tuse = 1; apply("r8_tnew1", 1);

    // Fill r9 to three writers, fourth is refused, one commit frees it.
    for (int i = 0; i < 3; i++) begin clr(); iss(9, 1); apply("iss_r9", 1); end
    clr(); iss(9, 1); query_rs = 9; apply("r9_full", 1);
    clr(); iss(9, 1); query_rs = 9; apply("r9_full_again", 1);
    clr(); cmt(9); issue_rd = 9; apply("r9_commit", 1);
    clr(); issue_rd = 9; query_rs = 9; apply("r9_ready", 1);

    // Same-cycle issue and commit on r4 with one writer pending.
    clr(); iss(4, 5); apply("iss_r4", 1);
    clr(); iss(4, 2); cmt(4); query_rt = 4; apply("r4_iss_cmt", 1);
    clr(); query_rt = 4; use_rt = 1; apply("r4_tnew2", 1);
    clr(); cmt(4); query_rt = 4; apply("r4_last_cmt", 1);
    clr(); query_rt = 4; apply("r4_idle", 1);

    // Underflow is sticky; register 0 never becomes busy.
    clr(); cmt(12); apply("cmt_r12_empty", 1);
    clr(); iss(0, 7); query_rs = 0; use_rs = 1; apply("err_set", 1);
    clr(); query_rs = 0; use_rs = 1; apply("r0_idle", 1);
    clr(); apply("err_hold", 1);

    // Reset while r3 has two writers and Tnew 4.
    clr(); iss(3, 6); apply("iss_r3a", 1);
    clr(); iss(3, 4); apply("iss_r3b", 1);
    clr(); reset = 1; query_rs = 3; use_rs = 1; apply("r3_pending", 1);
    clr(); query_rs = 3; use_rs = 1; apply("r3_after_reset", 1);

    // Random traffic on a small register window to force collisions.
    for (int n = 0; n < 800; n++) begin
      clr();
      if (n % 200 == 199) reset = 1;
      if ($urandom_range(0, 2) != 0) iss($urandom_range(0, 6), $urandom_range(0, 7));
      if ($urandom_range(0, 2) == 0) cmt($urandom_range(0, 6));
      if (issue_valid && commit_valid && issue_rd == commit_rd &&
          issue_rd != 0 && m_cnt[issue_rd] == 0) commit_valid = 0;
      query_rs = 5'($urandom_range(0, 6));
      query_rt = 5'($urandom_range(0, 6));
      use_rs   = 1'($urandom_range(0, 1));
      use_rt   = 1'($urandom_range(0, 1));
      rs_tuse  = 2'($urandom_range(0, 3));
      rt_tuse  = 2'($urandom_range(0, 3));
      apply("random", 1);
    end
    clr();

    budget = 20;
    while (q.size() > 0 && budget > 0) begin @(negedge clk); budget--; end
    @(negedge clk);
    if (q.size() > 0) begin
      n_fail++;
      $display("FAIL drain: %0d items left, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_scoreboard.md
REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 SHALL have port clk, input, 1 bit, system clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit; reset is synchronous and active-high; the clock is clk.
REQ-003 SHALL have port issue_valid, input, 1 bit, an instruction with a GPR destination enters the pipeline this cycle.
REQ-004 SHALL have port issue_rd, input, 5 bits, destination register of the issuing instruction.
REQ-005 SHALL have port issue_lat, input, 3 bits, cycles until the result is forwardable (Tnew at issue).
REQ-006 SHALL have port issue_ready, output, 1 bit, high when the issue can be accepted.
REQ-007 SHALL have port commit_valid, input, 1 bit, a GRF write-back with write enable fires this cycle.
REQ-008 SHALL have port commit_rd, input, 5 bits, register written by the commit.
REQ-009 SHALL have ports query_rs and query_rt, input, 5 bits each, source registers of the instruction in decode.
REQ-010 SHALL have ports use_rs and use_rt, input, 1 bit each, source actually read.
REQ-011 SHALL have ports rs_tuse and rt_tuse, input, 2 bits each, cycles until the source value is needed.
REQ-012 SHALL have ports rs_busy and rt_busy, output, 1 bit each, source has an outstanding write.
REQ-013 SHALL have ports rs_tnew and rt_tnew, output, 3 bits each, remaining Tnew of the newest pending write.
REQ-014 SHALL have port stall, output, 1 bit, decode must hold.
REQ-015 SHALL have port err_underflow, output, 1 bit, sticky flag for a commit with nothing pending.

Function
REQ-016 SHALL keep per register 1..31 a 2-bit pending count cnt[r] and a 3-bit tnew[r].
REQ-017 SHALL treat register 0 as never busy: ignore issues and commits to 0, report busy=0 and tnew=0.
REQ-018 SHALL drive issue_ready=0 only when issue_rd!=0 and cnt[issue_rd]==3; otherwise 1 (combinational).
REQ-019 SHALL ignore an issue when issue_ready=0: no state change.
REQ-020 SHALL, on an accepted issue, increment cnt[issue_rd] and load tnew[issue_rd]=issue_lat (newest writer wins, WAW).
REQ-021 SHALL, on a commit with cnt[commit_rd]>0, decrement cnt[commit_rd].
REQ-022 SHALL, on a commit with cnt[commit_rd]==0 and commit_rd!=0, leave state unchanged and set err_underflow=1 until reset.
REQ-023 SHALL, on an issue and a commit to the same register in one cycle, keep cnt unchanged and load tnew=issue_lat.
REQ-024 SHALL decrement every nonzero tnew[r] not being loaded by 1 per cycle, saturating at 0.
REQ-025 SHALL set tnew[r] to 0 when cnt[r] becomes 0.
REQ-026 SHALL compute the query outputs combinationally from registered state only; an issue or commit in the same cycle becomes visible after the edge.
REQ-027 SHALL drive x_busy=(cnt[query_x]!=0) and x_tnew=tnew[query_x], for x in rs/rt.
REQ-028 SHALL drive stall=(use_rs & rs_busy & rs_tnew>rs_tuse) | (use_rt & rt_busy & rt_tnew>rt_tuse), comparing zero-extended values.

Reset
REQ-029 SHALL, while reset=1 at a clk edge, clear all cnt, tnew and err_underflow; issue and commit inputs in that cycle are ignored.
REQ-030 SHALL drive the following after reset: issue_ready=1, rs_busy=rt_busy=0, rs_tnew=rt_tnew=0, stall=0, err_underflow=0.

Configuration
REQ-031 SHALL, with macro REG_SCOREBOARD_TRACE_EN defined, print on each accepted issue and each commit to a nonzero register one $display line with the following fields: time, event (ISS/CMT), register number, and cnt after the update.
REQ-032 SHALL, without REG_SCOREBOARD_TRACE_EN, contain no $display statements; function is otherwise identical.

Verification
REQ-033 SHALL verify the following case. Stimulus: reset, then query_rs=5 with use_rs=1. Required response: rs_busy=0, stall=0, issue_ready=1.
REQ-034 SHALL verify the following case. Stimulus: issue rd=8 with lat=3, then query rs=8 with tuse=1. Required response: after the next edge rs_tnew=3 and stall=1; rs_tnew then reads 2, then 1 with stall=0.
REQ-035 SHALL verify the following case. Stimulus: three issues to rd=9, then a fourth. Required response: issue_ready=0 and cnt remains 3; one commit to rd=9 restores issue_ready=1.
REQ-036 SHALL verify the following case. Stimulus: same-cycle issue rd=4 with lat=2 and commit rd=4 while cnt=1. Required response: cnt stays 1 and rt_tnew=2 next cycle.
REQ-037 SHALL verify the following case. Stimulus: commit rd=12 with nothing pending. Required response: err_underflow=1 and holds; issue rd=0 with lat=7 leaves rs_busy=0 for query 0.
REQ-038 SHALL verify the following case. Stimulus: reset asserted while cnt[3]=2 and tnew[3]=4. Required response: next cycle rs_busy=0 for query 3 and stall=0.
